// File: rtl/sprite_cmd_dispatcher.sv
// Sprite command dispatcher: Avalon-MM command FIFO feeding the broadcast sprite command bus.
// Owns ping/pong front-buffer selection and defers buffer swaps to vertical blanking.
module sprite_cmd_dispatcher #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [9:0]  VACTIVE    = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    DISPATCH,
    WAIT_VBL
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        overflow, flush_pending, flushed_this_frame;

  logic        push_req, push_ok, pop, full, empty, vblank, status_rd;
  logic        set_flush, do_swap;
  logic [31:0] head, cmd_nxt;
  logic [4:0]  count_stat;

  assign push_req   = chipselect & write & ~address;
  assign status_rd  = chipselect & read;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign vblank     = (vcount >= VACTIVE);
  assign count_stat = 5'(count);
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push_ok    = push_req & (~full | pop);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cmd_nxt   = '0;
    set_flush = 1'b0;
    do_swap   = 1'b0;
    unique case (state)
      DISPATCH: begin
        if (!empty) begin
          pop = 1'b1;
          case (head[20:17])
            4'b0001: cmd_nxt = {head[31:14], ~front_buf, head[12:0]};
            4'b1111: begin
              set_flush = 1'b1;
              state_nxt = WAIT_VBL;
            end
            default: ;
          endcase
        end
      end
      WAIT_VBL: begin
        if (vblank && !flushed_this_frame) begin
          cmd_nxt   = {6'b0, 5'b0, 4'b1111, 3'b0, ~front_buf, 13'b0};
          do_swap   = 1'b1;
          state_nxt = DISPATCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= DISPATCH;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      overflow           <= 1'b0;
      flush_pending      <= 1'b0;
      flushed_this_frame <= 1'b0;
      front_buf          <= 1'b0;
      cmd_out            <= '0;
      readdata           <= '0;
    end else begin
      state   <= state_nxt;
      cmd_out <= cmd_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Captured value reflects the pre-edge overflow; a fresh drop beats the clear.
      if (status_rd)
        readdata <= address ? {24'b0, overflow, flush_pending, front_buf, count_stat} : '0;
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (status_rd && address)
        overflow <= 1'b0;
      if (set_flush)
        flush_pending <= 1'b1;
      else if (do_swap)
        flush_pending <= 1'b0;
      if (do_swap) begin
        front_buf          <= ~front_buf;
        flushed_this_frame <= 1'b1;
      end else if (!vblank) begin
        flushed_this_frame <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_cmd_dispatcher.sv
// Directed self-checking bench for sprite_cmd_dispatcher.
module tb_sprite_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read, address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        front_buf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  sprite_cmd_dispatcher #(.FIFO_DEPTH(16), .VACTIVE(10'd480)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .vcount(vcount),
    .cmd_out(cmd_out), .front_buf(front_buf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0; write = 1'b0; read = 1'b0; address = 1'b0; writedata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = 1'b0; writedata = w;
    tick();
  endtask

  task automatic status_read(input logic adr);
    chipselect = 1'b1; write = 1'b0; read = 1'b1; address = adr; writedata = '0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    vcount = 10'd100;
    do_reset();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL reset_cmd got=%h exp=%h", cmd_out, 32'h0); end
    n_tests++;
    if (front_buf !== 1'b0) begin n_fail++; $display("FAIL reset_front got=%b exp=0", front_buf); end
    n_tests++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rd got=%h exp=%h", readdata, 32'h0); end
    status_read(1'b1);
    n_tests++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", readdata, 32'h0); end
  endtask

  task automatic test_single();
    do_reset();
    vcount = 10'd100;
    push(32'h14020400);
    idle();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL single_pre got=%h exp=0", cmd_out); end
    tick();
    n_tests++;
    if (cmd_out !== 32'h14022400) begin n_fail++; $display("FAIL single_cmd got=%h exp=%h", cmd_out, 32'h14022400); end
    tick();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL single_post got=%h exp=0", cmd_out); end
    n_tests++;
    if (front_buf !== 1'b0) begin n_fail++; $display("FAIL single_front got=%b exp=0", front_buf); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    logic [31:0] e [4];
    w = '{32'h14020400, 32'h08021001, 32'h0C022002, 32'h3F020005};
    e = '{32'h14022400, 32'h08023001, 32'h0C022002, 32'h3F022005};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(w[i]);
      if (i >= 1) begin
        n_tests++;
        if (cmd_out !== e[i-1]) begin n_fail++; $display("FAIL b2b_%0d got=%h exp=%h", i-1, cmd_out, e[i-1]); end
      end
    end
    idle();
    tick();
    n_tests++;
    if (cmd_out !== e[3]) begin n_fail++; $display("FAIL b2b_3 got=%h exp=%h", cmd_out, e[3]); end
    tick();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL b2b_tail got=%h exp=0", cmd_out); end
  endtask

  task automatic test_flush();
    do_reset();
    vcount = 10'd100;
    push(32'h001E0000);
    push(32'h14020400);
    idle();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL flush_hold_%0d got=%h exp=0", i, cmd_out); end
      tick();
    end
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL flush_hold_end got=%h exp=0", cmd_out); end
    status_read(1'b1);
    n_tests++;
    if (readdata !== 32'h00000041) begin n_fail++; $display("FAIL flush_pending_status got=%h exp=%h", readdata, 32'h41); end
    vcount = 10'd480;
    tick();
    n_tests++;
    if (cmd_out !== 32'h001E2000) begin n_fail++; $display("FAIL flush_word got=%h exp=%h", cmd_out, 32'h001E2000); end
    n_tests++;
    if (front_buf !== 1'b1) begin n_fail++; $display("FAIL flush_front got=%b exp=1", front_buf); end
    tick();
    n_tests++;
    if (cmd_out !== 32'h14020400) begin n_fail++; $display("FAIL flush_after got=%h exp=%h", cmd_out, 32'h14020400); end
    tick();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL flush_tail got=%h exp=0", cmd_out); end
  endtask

  task automatic test_one_swap_per_frame();
    do_reset();
    vcount = 10'd480;
    push(32'h001E0000);
    push(32'h001E0000);
    idle();
    tick();
    n_tests++;
    if (cmd_out !== 32'h001E2000) begin n_fail++; $display("FAIL swap1_word got=%h exp=%h", cmd_out, 32'h001E2000); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL swap_block_%0d got=%h exp=0", i, cmd_out); end
    end
    n_tests++;
    if (front_buf !== 1'b1) begin n_fail++; $display("FAIL swap_mid_front got=%b exp=1", front_buf); end
    vcount = 10'd0;
    tick();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL swap_active got=%h exp=0", cmd_out); end
    vcount = 10'd480;
    tick();
    n_tests++;
    if (cmd_out !== 32'h001E0000) begin n_fail++; $display("FAIL swap2_word got=%h exp=%h", cmd_out, 32'h001E0000); end
    n_tests++;
    if (front_buf !== 1'b0) begin n_fail++; $display("FAIL swap2_front got=%b exp=0", front_buf); end
  endtask

  task automatic test_overflow();
    do_reset();
    vcount = 10'd100;
    push(32'h001E0000);
    for (int i = 0; i < 17; i++) push(32'h14020400 + 32'(i));
    idle();
    status_read(1'b1);
    n_tests++;
    if (readdata !== 32'h000000D0) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", readdata, 32'hD0); end
    status_read(1'b1);
    n_tests++;
    if (readdata !== 32'h00000050) begin n_fail++; $display("FAIL ovf_clear got=%h exp=%h", readdata, 32'h50); end
    status_read(1'b0);
    n_tests++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL addr0_read got=%h exp=0", readdata); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    vcount = 10'd100;
    push(32'h14020400);
    push(32'h14020401);
    push(32'h14020402);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL mid_reset_cmd got=%h exp=0", cmd_out); end
    n_tests++;
    if (front_buf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_front got=%b exp=0", front_buf); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL mid_reset_quiet_%0d got=%h exp=0", i, cmd_out); end
    end
    status_read(1'b1);
    n_tests++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_status got=%h exp=0", readdata); end
  endtask

  task automatic test_discard();
    do_reset();
    vcount = 10'd100;
    push(32'h000A0000);
    idle();
    tick();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL discard_cmd got=%h exp=0", cmd_out); end
    status_read(1'b1);
    n_tests++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL discard_count got=%h exp=0", readdata); end
    chipselect = 1'b1; write = 1'b1; address = 1'b1; writedata = 32'h14020400;
    tick();
    idle();
    tick();
    n_tests++;
    if (cmd_out !== 32'h0) begin n_fail++; $display("FAIL addr1_write got=%h exp=0", cmd_out); end
  endtask

  initial begin
    idle();
    reset  = 1'b0;
    vcount = 10'd100;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_one_swap_per_frame();
    test_overflow();
    test_reset_mid_drain();
    test_discard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
